// File: rtl/id_ex_stage_pkg.sv
// Shared constants, ALU op codes and the pipeline-control bundle for the
// ID/EX stage. Optional feature macro used by the stage: ID_EX_FWD_EN.
package id_ex_stage_pkg;

  localparam int WIDTH = 16;
  localparam int OPW   = 5;
  localparam int RW    = 3;

  localparam logic [OPW-1:0] OP_ADD  = 5'd0;
  localparam logic [OPW-1:0] OP_SUB  = 5'd1;
  localparam logic [OPW-1:0] OP_AND  = 5'd2;
  localparam logic [OPW-1:0] OP_OR   = 5'd3;
  localparam logic [OPW-1:0] OP_XOR  = 5'd4;
  localparam logic [OPW-1:0] OP_NOT  = 5'd5;
  localparam logic [OPW-1:0] OP_SHL  = 5'd6;
  localparam logic [OPW-1:0] OP_SHR  = 5'd7;
  localparam logic [OPW-1:0] OP_SRA  = 5'd8;
  localparam logic [OPW-1:0] OP_ROL  = 5'd9;
  localparam logic [OPW-1:0] OP_ROR  = 5'd10;
  localparam logic [OPW-1:0] OP_SLT  = 5'd11;
  localparam logic [OPW-1:0] OP_SLTU = 5'd12;
  localparam logic [OPW-1:0] OP_MOV  = 5'd13;
  localparam logic [OPW-1:0] OP_LUI  = 5'd14;
  localparam logic [OPW-1:0] OP_LD   = 5'd15;
  localparam logic [OPW-1:0] OP_ST   = 5'd16;
  localparam logic [OPW-1:0] OP_BEQ  = 5'd17;
  localparam logic [OPW-1:0] OP_BTR  = 5'd18;

  // Control bits that travel with an instruction down the pipe.
  typedef struct packed {
    logic          valid;
    logic          wr_en;
    logic          mem_rd;
    logic          mem_wr;
    logic [RW-1:0] rd;
  } pipe_ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand select for one ALU input: EX/MEM result, then MEM/WB result, then
// the registered value. With ID_EX_FWD_EN undefined the registered value
// passes straight through.
module id_ex_stage_fwd_mux #(
  parameter int WIDTH = 16,
  parameter int RW    = 3
) (
  input  logic [RW-1:0]    idx,
  input  logic             used,
  input  logic [WIDTH-1:0] reg_val,
  input  logic             src1_en,
  input  logic [RW-1:0]    src1_rd,
  input  logic [WIDTH-1:0] src1_data,
  input  logic             src2_en,
  input  logic [RW-1:0]    src2_rd,
  input  logic [WIDTH-1:0] src2_data,
  output logic [WIDTH-1:0] val
);

`ifdef ID_EX_FWD_EN
  // The nearer producer (src1 = EX/MEM) wins when both match.
  always_comb begin
    val = reg_val;
    if (used && src1_en && (src1_rd == idx)) begin
      val = src1_data;
    end else if (used && src2_en && (src2_rd == idx)) begin
      val = src2_data;
    end
  end
`else
  logic unused_src;
  assign unused_src = ^{idx, used, src1_en, src1_rd, src1_data,
                        src2_en, src2_rd, src2_data};

  // No forwarding: hazards are resolved by stalling instead.
  always_comb begin
    val = reg_val;
  end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding muxes in front of the ALU,
// load-use bubble insertion, hold and flush.
// Macro ID_EX_FWD_EN enables forwarding; without it every RAW hazard stalls.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int WIDTH = id_ex_stage_pkg::WIDTH,
  parameter int OPW   = id_ex_stage_pkg::OPW,
  parameter int RW    = id_ex_stage_pkg::RW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic [OPW-1:0]   in_Op,
  input  logic [RW-1:0]    in_rs,
  input  logic [RW-1:0]    in_rt,
  input  logic [RW-1:0]    in_rd,
  input  logic             in_rs_used,
  input  logic             in_rt_used,
  input  logic             in_use_imm,
  input  logic             in_wr_en,
  input  logic             in_mem_rd,
  input  logic             in_mem_wr,
  input  logic             ext_stall,
  input  logic             flush,
  input  logic             exmem_wr_en,
  input  logic             memwb_wr_en,
  input  logic [RW-1:0]    exmem_rd,
  input  logic [RW-1:0]    memwb_rd,
  input  logic [WIDTH-1:0] exmem_data,
  input  logic [WIDTH-1:0] memwb_data,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_A,
  output logic [WIDTH-1:0] ex_B,
  output logic [OPW-1:0]   ex_Op,
  output logic [RW-1:0]    ex_rd,
  output logic             ex_wr_en,
  output logic             ex_mem_rd,
  output logic             ex_mem_wr,
  output logic [WIDTH-1:0] ex_store_data,
  output logic             hazard_stall
);

  pipe_ctrl_t       ctrl_q;
  logic [WIDTH-1:0] a_q, b_q, st_q;
  logic [OPW-1:0]   op_q;
  logic [RW-1:0]    rs_q, rt_q;
  logic             rs_used_q, rt_used_q, use_imm_q;

  logic             hazard_raw;
  logic             kill;
  logic             hit_ex;

  // Does the decode instruction read register r? Stores read rt even when
  // the B operand slot carries an immediate.
  function automatic logic reads_reg(input logic [RW-1:0] r,
                                     input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                                     input logic rs_used, input logic rt_used,
                                     input logic use_imm, input logic mem_wr);
    return (rs_used && rs == r) || (rt_used && !use_imm && rt == r) ||
           (mem_wr && rt == r);
  endfunction

  assign hit_ex = reads_reg(ctrl_q.rd, in_rs, in_rt, in_rs_used, in_rt_used,
                            in_use_imm, in_mem_wr);

`ifdef ID_EX_FWD_EN
  // Only a load in EX cannot be forwarded in time.
  assign hazard_raw = ctrl_q.valid && ctrl_q.mem_rd && ctrl_q.wr_en &&
                      in_valid && hit_ex;
`else
  logic hit_exmem, hit_memwb;
  assign hit_exmem = reads_reg(exmem_rd, in_rs, in_rt, in_rs_used, in_rt_used,
                               in_use_imm, in_mem_wr);
  assign hit_memwb = reads_reg(memwb_rd, in_rs, in_rt, in_rs_used, in_rt_used,
                               in_use_imm, in_mem_wr);
  // Any pending writer of a source register stalls decode.
  assign hazard_raw = in_valid && ((ctrl_q.valid && ctrl_q.wr_en && hit_ex) ||
                                   (exmem_wr_en && hit_exmem) ||
                                   (memwb_wr_en && hit_memwb));
`endif

  assign hazard_stall = hazard_raw && !flush;
  // A flush, or a load-use bubble not overridden by a hold, empties the slot.
  assign kill = flush || (hazard_stall && !ext_stall);

  // Three operand selects: 0 = A on rs, 1 = B on rt (not for immediates),
  // 2 = store data on rt regardless of the immediate.
  logic [RW-1:0]    sel_idx  [3];
  logic             sel_used [3];
  logic [WIDTH-1:0] sel_reg  [3];
  logic [WIDTH-1:0] sel_out  [3];

  assign sel_idx[0]  = rs_q;
  assign sel_used[0] = rs_used_q;
  assign sel_reg[0]  = a_q;
  assign sel_idx[1]  = rt_q;
  assign sel_used[1] = rt_used_q && !use_imm_q;
  assign sel_reg[1]  = b_q;
  assign sel_idx[2]  = rt_q;
  assign sel_used[2] = 1'b1;
  assign sel_reg[2]  = st_q;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_fwd
      id_ex_stage_fwd_mux #(.WIDTH(WIDTH), .RW(RW)) u_mux (
        .idx      (sel_idx[gi]),
        .used     (sel_used[gi]),
        .reg_val  (sel_reg[gi]),
        .src1_en  (exmem_wr_en),
        .src1_rd  (exmem_rd),
        .src1_data(exmem_data),
        .src2_en  (memwb_wr_en),
        .src2_rd  (memwb_rd),
        .src2_data(memwb_data),
        .val      (sel_out[gi])
      );
    end
  endgenerate

  // Pipeline register: clear, hold (re-capturing forwarded operands), or load.
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      ctrl_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      st_q      <= '0;
      op_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rs_used_q <= 1'b0;
      rt_used_q <= 1'b0;
      use_imm_q <= 1'b0;
    end else if (ext_stall) begin
      a_q  <= sel_out[0];
      b_q  <= sel_out[1];
      st_q <= sel_out[2];
    end else begin
      ctrl_q.valid  <= in_valid;
      ctrl_q.wr_en  <= in_wr_en;
      ctrl_q.mem_rd <= in_mem_rd;
      ctrl_q.mem_wr <= in_mem_wr;
      ctrl_q.rd     <= in_rd;
      a_q           <= in_A;
      b_q           <= in_B;
      st_q          <= in_B;
      op_q          <= in_Op;
      rs_q          <= in_rs;
      rt_q          <= in_rt;
      rs_used_q     <= in_rs_used;
      rt_used_q     <= in_rt_used;
      use_imm_q     <= in_use_imm;
    end
  end

  assign ex_valid      = ctrl_q.valid;
  assign ex_wr_en      = ctrl_q.wr_en && ctrl_q.valid;
  assign ex_mem_rd     = ctrl_q.mem_rd && ctrl_q.valid;
  assign ex_mem_wr     = ctrl_q.mem_wr && ctrl_q.valid;
  assign ex_rd         = ctrl_q.rd;
  assign ex_Op         = op_q;
  assign ex_A          = sel_out[0];
  assign ex_B          = sel_out[1];
  assign ex_store_data = sel_out[2];

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; expectations follow ID_EX_FWD_EN.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_rs_used, in_rt_used, in_use_imm;
  logic        in_wr_en, in_mem_rd, in_mem_wr, ext_stall, flush;
  logic        exmem_wr_en, memwb_wr_en;
  logic [15:0] in_A, in_B, exmem_data, memwb_data;
  logic [4:0]  in_Op;
  logic [2:0]  in_rs, in_rt, in_rd, exmem_rd, memwb_rd;
  logic        ex_valid, ex_wr_en, ex_mem_rd, ex_mem_wr, hazard_stall;
  logic [15:0] ex_A, ex_B, ex_store_data;
  logic [4:0]  ex_Op;
  logic [2:0]  ex_rd;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_A(in_A), .in_B(in_B),
    .in_Op(in_Op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_rs_used(in_rs_used), .in_rt_used(in_rt_used), .in_use_imm(in_use_imm),
    .in_wr_en(in_wr_en), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
    .ext_stall(ext_stall), .flush(flush),
    .exmem_wr_en(exmem_wr_en), .memwb_wr_en(memwb_wr_en),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_data(exmem_data), .memwb_data(memwb_data),
    .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B), .ex_Op(ex_Op), .ex_rd(ex_rd),
    .ex_wr_en(ex_wr_en), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_store_data(ex_store_data), .hazard_stall(hazard_stall)
  );

  typedef struct packed {
    logic valid, wr_en, mem_rd, mem_wr;
    logic [2:0]  rd;
    logic [4:0]  op;
    logic [15:0] a, b, st;
  } ex_t;

  ex_t sbq[$];
  ex_t obs, exp_v;
  int  n_chk = 0;
  int  n_fail = 0;

  function automatic ex_t mk(input logic v, w, mr, mw, input logic [2:0] rd,
                             input logic [4:0] op, input logic [15:0] a, b, st);
    ex_t e;
    e = {v, w, mr, mw, rd, op, a, b, st};
    return e;
  endfunction

  function automatic ex_t cur_ex();
    ex_t e;
    e = {ex_valid, ex_wr_en, ex_mem_rd, ex_mem_wr, ex_rd, ex_Op, ex_A, ex_B, ex_store_data};
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 0; in_valid = 0; in_A = 0; in_B = 0; in_Op = 0;
    in_rs = 0; in_rt = 0; in_rd = 0; in_rs_used = 0; in_rt_used = 0;
    in_use_imm = 0; in_wr_en = 0; in_mem_rd = 0; in_mem_wr = 0;
    ext_stall = 0; flush = 0; exmem_wr_en = 0; memwb_wr_en = 0;
    exmem_rd = 0; memwb_rd = 0; exmem_data = 0; memwb_data = 0;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [15:0] a, b,
                       input logic [2:0] rs, rt, rd,
                       input logic rsu, rtu, imm, wr, mrd, mwr);
    in_valid = v; in_Op = op; in_A = a; in_B = b;
    in_rs = rs; in_rt = rt; in_rd = rd;
    in_rs_used = rsu; in_rt_used = rtu; in_use_imm = imm;
    in_wr_en = wr; in_mem_rd = mrd; in_mem_wr = mwr;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    drive(1, OP_ADD, 16'h1234, 16'h5678, 3'd1, 3'd2, 3'd3, 1, 1, 0, 1, 0, 0);
    sbq.push_back('0);
    step();
    obs = cur_ex(); exp_v = sbq.pop_front(); n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset_state: got %h expected %h", obs, exp_v); end
    else $display("ok   reset_state %h", obs);
    n_chk++;
    if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b expected 0", hazard_stall); end
    else $display("ok   reset_hazard");
  endtask

  task automatic test_back_to_back();
    logic exp_hz;
    clear_inputs();
    drive(1, OP_ADD, 16'h0010, 16'h0020, 3'd1, 3'd2, 3'd3, 1, 1, 0, 1, 0, 0);
    sbq.push_back(mk(1, 1, 0, 0, 3'd3, OP_ADD, 16'h0010, 16'h0020, 16'h0020));
    step();
    obs = cur_ex(); exp_v = sbq.pop_front(); n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", obs, exp_v); end
    else $display("ok   b2b_first %h", obs);
    drive(1, OP_ADD, 16'h0000, 16'h0030, 3'd3, 3'd4, 3'd5, 1, 1, 0, 1, 0, 0);
    #1;
`ifdef ID_EX_FWD_EN
    exp_hz = 1'b0;
`else
    exp_hz = 1'b1;
`endif
    n_chk++;
    if (hazard_stall !== exp_hz) begin n_fail++; $display("FAIL b2b_hazard: got %b expected %b", hazard_stall, exp_hz); end
    else $display("ok   b2b_hazard %b", hazard_stall);
`ifdef ID_EX_FWD_EN
    sbq.push_back(mk(1, 1, 0, 0, 3'd5, OP_ADD, 16'h00A5, 16'h0030, 16'h0030));
    step();
    exmem_wr_en = 1; exmem_rd = 3'd3; exmem_data = 16'h00A5;
    #1;
`else
    sbq.push_back('0);
    step();
    obs = cur_ex(); exp_v = sbq.pop_front(); n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_bubble: got %h expected %h", obs, exp_v); end
    else $display("ok   b2b_bubble %h", obs);
    sbq.push_back(mk(1, 1, 0, 0, 3'd5, OP_ADD, 16'h0000, 16'h0030, 16'h0030));
    step();
`endif
    obs = cur_ex(); exp_v = sbq.pop_front(); n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", obs, exp_v); end
    else $display("ok   b2b_second %h", obs);
  endtask

  task automatic test_fwd_priority();
    logic [15:0] both_b, wb_b, imm_st;
`ifdef ID_EX_FWD_EN
    both_b = 16'h1111; wb_b = 16'h2222; imm_st = 16'h1111;
`else
    both_b = 16'h9999; wb_b = 16'h9999; imm_st = 16'h0007;
`endif
    clear_inputs();
    drive(1, OP_ADD, 16'h0000, 16'h9999, 3'd1, 3'd2, 3'd6, 0, 1, 0, 1, 0, 0);
    step();
    exmem_wr_en = 1; exmem_rd = 3'd2; exmem_data = 16'h1111;
    memwb_wr_en = 1; memwb_rd = 3'd2; memwb_data = 16'h2222;
    sbq.push_back(mk(1, 1, 0, 0, 3'd6, OP_ADD, 16'h0000, both_b, both_b));
    #1;
    obs = cur_ex(); exp_v = sbq.pop_front(); n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL prio_both: got %h expected %h", obs, exp_v); end
    else $display("ok   prio_both %h", obs);
    exmem_wr_en = 0;
    sbq.push_back(mk(1, 1, 0, 0, 3'd6, OP_ADD, 16'h0000, wb_b, wb_b));
    #1;
    obs = cur_ex(); exp_v = sbq.pop_front(); n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL prio_memwb: got %h expected %h", obs, exp_v); end
    else $display("ok   prio_memwb %h", obs);
    clear_inputs();
    drive(1, OP_ADD, 16'h0000, 16'h0007, 3'd1, 3'd2, 3'd6, 0, 1, 1, 1, 0, 0);
    step();
    exmem_wr_en = 1; exmem_rd = 3'd2; exmem_data = 16'h1111;
    sbq.push_back(mk(1, 1, 0, 0, 3'd6, OP_ADD, 16'h0000, 16'h0007, imm_st));
    #1;
    obs = cur_ex(); exp_v = sbq.pop_front(); n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL prio_imm: got %h expected %h", obs, exp_v); end
    else $display("ok   prio_imm %h", obs);
  endtask

  task automatic test_load_use();
    logic exp_hz;
    clear_inputs();
    drive(1, OP_LD, 16'h0100, 16'h0004, 3'd1, 3'd0, 3'd4, 1, 0, 1, 1, 1, 0);
    sbq.push_back(mk(1, 1, 1, 0, 3'd4, OP_LD, 16'h0100, 16'h0004, 16'h0004));
    step();
    obs = cur_ex(); exp_v = sbq.pop_front(); n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL lu_load: got %h expected %h", obs, exp_v); end
    else $display("ok   lu_load %h", obs);
    drive(1, OP_ADD, 16'h0000, 16'h0050, 3'd4, 3'd3, 3'd7, 1, 1, 0, 1, 0, 0);
    #1;
    n_chk++;
    if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL lu_hazard: got %b expected 1", hazard_stall); end
    else $display("ok   lu_hazard");
    sbq.push_back('0);
    step();
    obs = cur_ex(); exp_v = sbq.pop_front(); n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL lu_bubble: got %h expected %h", obs, exp_v); end
    else $display("ok   lu_bubble %h", obs);
    exmem_wr_en = 1; exmem_rd = 3'd4; exmem_data = 16'hCAFE;
    #1;
`ifdef ID_EX_FWD_EN
    exp_hz = 1'b0;
`else
    exp_hz = 1'b1;
`endif
    n_chk++;
    if (hazard_stall !== exp_hz) begin n_fail++; $display("FAIL lu_hazard_after: got %b expected %b", hazard_stall, exp_hz); end
    else $display("ok   lu_hazard_after %b", hazard_stall);
`ifdef ID_EX_FWD_EN
    sbq.push_back(mk(1, 1, 0, 0, 3'd7, OP_ADD, 16'hCAFE, 16'h0050, 16'h0050));
`else
    exmem_wr_en = 0;
    #1;
    n_chk++;
    if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL lu_hazard_clear: got %b expected 0", hazard_stall); end
    else $display("ok   lu_hazard_clear");
    sbq.push_back(mk(1, 1, 0, 0, 3'd7, OP_ADD, 16'h0000, 16'h0050, 16'h0050));
`endif
    step();
    obs = cur_ex(); exp_v = sbq.pop_front(); n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL lu_capture: got %h expected %h", obs, exp_v); end
    else $display("ok   lu_capture %h", obs);
  endtask

  task automatic test_flush_stall();
    clear_inputs();
    drive(1, OP_ST, 16'h0200, 16'h0003, 3'd1, 3'd7, 3'd0, 1, 0, 1, 0, 0, 1);
    flush = 1; ext_stall = 1;
    #1;
    n_chk++;
    if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL flush_hazard: got %b expected 0", hazard_stall); end
    else $display("ok   flush_hazard");
    sbq.push_back('0);
    step();
    obs = cur_ex(); exp_v = sbq.pop_front(); n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL flush_bubble: got %h expected %h", obs, exp_v); end
    else $display("ok   flush_bubble %h", obs);
  endtask

  task automatic test_hold();
    logic [15:0] exp_a;
`ifdef ID_EX_FWD_EN
    exp_a = 16'hBEEF;
`else
    exp_a = 16'h0000;
`endif
    clear_inputs();
    drive(1, OP_ADD, 16'h0000, 16'h0011, 3'd5, 3'd6, 3'd1, 1, 0, 0, 1, 0, 0);
    step();
    in_valid = 0; ext_stall = 1;
    memwb_wr_en = 1; memwb_rd = 3'd5; memwb_data = 16'hBEEF;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) memwb_wr_en = 0;
      if (i == 5) ext_stall = 0;
      if (i >= 4) #1;
      sbq.push_back(mk(1, 1, 0, 0, 3'd1, OP_ADD, exp_a, 16'h0011, 16'h0011));
      obs = cur_ex(); exp_v = sbq.pop_front(); n_chk++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL hold_%0d: got %h expected %h", i, obs, exp_v); end
      else $display("ok   hold_%0d %h", i, obs);
      if (i < 3) step();
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    drive(1, OP_SUB, 16'h0001, 16'h0002, 3'd3, 3'd2, 3'd2, 1, 1, 0, 1, 0, 0);
    sbq.push_back(mk(1, 1, 0, 0, 3'd2, OP_SUB, 16'h0001, 16'h0002, 16'h0002));
    step();
    obs = cur_ex(); exp_v = sbq.pop_front(); n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL rstmid_load: got %h expected %h", obs, exp_v); end
    else $display("ok   rstmid_load %h", obs);
    rst = 1;
    sbq.push_back('0);
    step();
    obs = cur_ex(); exp_v = sbq.pop_front(); n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL rstmid_clear: got %h expected %h", obs, exp_v); end
    else $display("ok   rstmid_clear %h", obs);
    rst = 0;
  endtask

  task automatic test_src_hazard();
    logic exp_hz;
`ifdef ID_EX_FWD_EN
    exp_hz = 1'b0;
`else
    exp_hz = 1'b1;
`endif
    clear_inputs();
    exmem_wr_en = 1; exmem_rd = 3'd3;
    drive(1, OP_ADD, 16'h0000, 16'h0000, 3'd3, 3'd0, 3'd5, 1, 0, 0, 1, 0, 0);
    #1;
    n_chk++;
    if (hazard_stall !== exp_hz) begin n_fail++; $display("FAIL src_exmem: got %b expected %b", hazard_stall, exp_hz); end
    else $display("ok   src_exmem %b", hazard_stall);
    exmem_wr_en = 0; memwb_wr_en = 1; memwb_rd = 3'd3;
    #1;
    n_chk++;
    if (hazard_stall !== exp_hz) begin n_fail++; $display("FAIL src_memwb: got %b expected %b", hazard_stall, exp_hz); end
    else $display("ok   src_memwb %b", hazard_stall);
    drive(1, OP_ST, 16'h0000, 16'h0004, 3'd0, 3'd3, 3'd0, 0, 0, 1, 0, 0, 1);
    #1;
    n_chk++;
    if (hazard_stall !== exp_hz) begin n_fail++; $display("FAIL src_store: got %b expected %b", hazard_stall, exp_hz); end
    else $display("ok   src_store %b", hazard_stall);
    memwb_wr_en = 0;
    #1;
    n_chk++;
    if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL src_noen: got %b expected 0", hazard_stall); end
    else $display("ok   src_noen");
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_back_to_back();
    test_fwd_priority();
    test_load_use();
    test_flush_stall();
    test_hold();
    test_reset_mid();
    test_src_hazard();
    if (sbq.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
